// File: rtl/ara_pkg.sv
// Shared lane types plus the result-arbiter requester enumeration.
// The arbiter uses the optional macro VFU_ARB_TMAC_EN; the package itself is
// identical in both builds.
package ara_pkg;

    // Lane element and address types.
    typedef logic [31:0] elen_t;
    typedef logic [2:0]  vid_t;
    typedef logic [9:0]  vaddr_t;

    localparam int unsigned DataWidth = $bits(elen_t);
    typedef logic [DataWidth/8-1:0] strb_t;

    // Requester slots of the VRF write-port arbiter. The value is the bit
    // position in the request/grant vectors.
    typedef enum logic [1:0] {ArbAlu, ArbMfpu, ArbTmac} vfu_arb_req_e;
    localparam int unsigned NrVfuArbReq = 3;

endpackage

// File: rtl/vfu_arb_age_ctr.sv
// Saturating age counter for one arbiter requester. It counts the cycles in
// which the requester asks but loses. The requester is promoted once the count
// reaches MaxWait.
module vfu_arb_age_ctr #(
    parameter int unsigned MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req,
    input  logic gnt,
    output logic promoted
);

    localparam int unsigned AgeW = $clog2(MaxWait + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(MaxWait);

    logic [AgeW-1:0] age;

    // Age while losing, hold at the ceiling, clear on grant or on withdrawal.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age <= '0;
        end else if (req && !gnt) begin
            if (age != AgeMax) begin
                age <= age + 1'b1;
            end
        end else begin
            age <= '0;
        end
    end

    assign promoted = (age == AgeMax);

endmodule

// File: rtl/vfu_result_arbiter.sv
// Shares one VRF write port between the ALU, MFPU and TMAC result streams.
// The fixed priority is MFPU > ALU > TMAC. A requester that has lost MaxWait
// cycles in a row is promoted above every requester that is not promoted.
// The winner is captured in a single-entry output stage.
// Optional macro VFU_ARB_TMAC_EN: when it is undefined, TMAC is left out of
// arbitration. The TMAC ports stay on the module.
//
// Handshake: each requester holds req and its payload stable until its gnt is
// high, and the transfer happens on that clock edge. The output stage presents
// wr_req_o with its payload until the VRF answers with wr_gnt_i; that cycle is
// the transfer. A capture in the same cycle reloads the stage.
module vfu_result_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned MaxWait = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     alu_req_i,
    input  logic     mfpu_req_i,
    input  logic     tmac_req_i,
    input  vid_t     alu_id_i,
    input  vid_t     mfpu_id_i,
    input  vid_t     tmac_id_i,
    input  vaddr_t   alu_addr_i,
    input  vaddr_t   mfpu_addr_i,
    input  vaddr_t   tmac_addr_i,
    input  elen_t    alu_wdata_i,
    input  elen_t    mfpu_wdata_i,
    input  elen_t    tmac_wdata_i,
    input  strb_t    alu_be_i,
    input  strb_t    mfpu_be_i,
    input  strb_t    tmac_be_i,
    output logic     alu_gnt_o,
    output logic     mfpu_gnt_o,
    output logic     tmac_gnt_o,
    output logic     wr_req_o,
    output vid_t     wr_id_o,
    output vaddr_t   wr_addr_o,
    output elen_t    wr_wdata_o,
    output strb_t    wr_be_o,
    input  logic     wr_gnt_i,
    output logic     busy_o
);

    logic [NrVfuArbReq-1:0] req;
    logic [NrVfuArbReq-1:0] prom;
    logic [NrVfuArbReq-1:0] hot;
    logic [NrVfuArbReq-1:0] pool;
    logic [NrVfuArbReq-1:0] gnt;
    logic                   can_accept;
    logic                   valid;
    vid_t                   sel_id;
    vaddr_t                 sel_addr;
    elen_t                  sel_wdata;
    strb_t                  sel_be;

    assign req[ArbAlu]  = alu_req_i;
    assign req[ArbMfpu] = mfpu_req_i;

    vfu_arb_age_ctr #(.MaxWait(MaxWait)) i_age_alu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (req[ArbAlu]),
        .gnt      (gnt[ArbAlu]),
        .promoted (prom[ArbAlu])
    );

    vfu_arb_age_ctr #(.MaxWait(MaxWait)) i_age_mfpu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (req[ArbMfpu]),
        .gnt      (gnt[ArbMfpu]),
        .promoted (prom[ArbMfpu])
    );

`ifdef VFU_ARB_TMAC_EN
    assign req[ArbTmac] = tmac_req_i;

    vfu_arb_age_ctr #(.MaxWait(MaxWait)) i_age_tmac (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (req[ArbTmac]),
        .gnt      (gnt[ArbTmac]),
        .promoted (prom[ArbTmac])
    );
`else
    // TMAC never competes; its request is deliberately unused.
    logic unused_tmac_req;
    assign unused_tmac_req = tmac_req_i;
    assign req[ArbTmac]    = 1'b0;
    assign prom[ArbTmac]   = 1'b0;
`endif

    // A promoted requester is only live while it still asks. If nobody is
    // promoted, every requester competes on base priority.
    assign hot        = req & prom;
    assign pool       = (|hot) ? hot : req;
    assign can_accept = !valid || wr_gnt_i;

    // Pick one winner from the pool using base priority. There is no grant
    // while the stage is full.
    always_comb begin
        gnt = '0;
        if (can_accept) begin
            if (pool[ArbMfpu]) begin
                gnt[ArbMfpu] = 1'b1;
            end else if (pool[ArbAlu]) begin
                gnt[ArbAlu] = 1'b1;
            end else if (pool[ArbTmac]) begin
                gnt[ArbTmac] = 1'b1;
            end
        end
    end

    assign alu_gnt_o  = gnt[ArbAlu];
    assign mfpu_gnt_o = gnt[ArbMfpu];
    assign tmac_gnt_o = gnt[ArbTmac];

    // Steer the winner's payload. The grant selects it, so the payload never
    // feeds back into the grant.
    always_comb begin
        sel_id    = alu_id_i;
        sel_addr  = alu_addr_i;
        sel_wdata = alu_wdata_i;
        sel_be    = alu_be_i;
        if (gnt[ArbMfpu]) begin
            sel_id    = mfpu_id_i;
            sel_addr  = mfpu_addr_i;
            sel_wdata = mfpu_wdata_i;
            sel_be    = mfpu_be_i;
        end else if (gnt[ArbTmac]) begin
            sel_id    = tmac_id_i;
            sel_addr  = tmac_addr_i;
            sel_wdata = tmac_wdata_i;
            sel_be    = tmac_be_i;
        end
    end

    // Output stage: capture the winner (this also reloads on a drain), else
    // drain when the VRF takes the word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid      <= 1'b0;
            wr_id_o    <= '0;
            wr_addr_o  <= '0;
            wr_wdata_o <= '0;
            wr_be_o    <= '0;
        end else if (|gnt) begin
            valid      <= 1'b1;
            wr_id_o    <= sel_id;
            wr_addr_o  <= sel_addr;
            wr_wdata_o <= sel_wdata;
            wr_be_o    <= sel_be;
        end else if (wr_gnt_i) begin
            valid      <= 1'b0;
        end
    end

    assign wr_req_o = valid;
    assign busy_o   = valid || (|req);

endmodule

// File: tb/tb_vfu_result_arbiter.sv
// Scoreboard bench for vfu_result_arbiter. A reference model predicts grants
// and output-stage occupancy. Captured payloads go into a queue. A monitor
// checks each presented output word against that queue.
module tb_vfu_result_arbiter;
  import ara_pkg::*;

  localparam int unsigned MaxWait = 4;
`ifdef VFU_ARB_TMAC_EN
  localparam bit TmacEn = 1'b1;
`else
  localparam bit TmacEn = 1'b0;
`endif

  typedef struct packed {
    vid_t   id;
    vaddr_t addr;
    elen_t  data;
    strb_t  be;
  } wr_t;
  localparam int PW = $bits(wr_t);

  // requester slots: 0 = ALU, 1 = MFPU, 2 = TMAC
  logic   clk;
  logic   rst_i;
  logic   wr_gnt_i;
  bit     rq[3];
  wr_t    pl[3];
  logic   alu_gnt_o, mfpu_gnt_o, tmac_gnt_o;
  logic   wr_req_o, busy_o;
  vid_t   wr_id_o;
  vaddr_t wr_addr_o;
  elen_t  wr_wdata_o;
  strb_t  wr_be_o;

  logic [PW-1:0] exp_q[$];
  int  lose_cnt[3];
  bit  m_valid;
  int  n_checks;
  int  n_pass;

  vfu_result_arbiter #(.MaxWait(MaxWait)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .alu_req_i    (rq[0]),
    .mfpu_req_i   (rq[1]),
    .tmac_req_i   (rq[2]),
    .alu_id_i     (pl[0].id),
    .mfpu_id_i    (pl[1].id),
    .tmac_id_i    (pl[2].id),
    .alu_addr_i   (pl[0].addr),
    .mfpu_addr_i  (pl[1].addr),
    .tmac_addr_i  (pl[2].addr),
    .alu_wdata_i  (pl[0].data),
    .mfpu_wdata_i (pl[1].data),
    .tmac_wdata_i (pl[2].data),
    .alu_be_i     (pl[0].be),
    .mfpu_be_i    (pl[1].be),
    .tmac_be_i    (pl[2].be),
    .alu_gnt_o    (alu_gnt_o),
    .mfpu_gnt_o   (mfpu_gnt_o),
    .tmac_gnt_o   (tmac_gnt_o),
    .wr_req_o     (wr_req_o),
    .wr_id_o      (wr_id_o),
    .wr_addr_o    (wr_addr_o),
    .wr_wdata_o   (wr_wdata_o),
    .wr_be_o      (wr_be_o),
    .wr_gnt_i     (wr_gnt_i),
    .busy_o       (busy_o)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic wr_t rand_pl();
    wr_t p;
    p.id   = vid_t'($urandom);
    p.addr = vaddr_t'($urandom);
    p.data = $urandom;
    p.be   = strb_t'($urandom_range(1, 15));
    return p;
  endfunction

  // One cycle: inputs are already set just after the falling edge. Predict
  // the winner from the rules: anyone who has lost MaxWait cycles goes first,
  // then MFPU, ALU, TMAC. Check the DUT, update the model and move to the
  // next falling edge.
  task automatic step(output int win, output logic [2:0] seen);
    int  order[3];
    bit  en[3];
    bit  can;
    logic [2:0] eg;
    order = '{1, 0, 2};
    #1;
    for (int r = 0; r < 3; r++) en[r] = rq[r] && (r != 2 || TmacEn);
    can = !m_valid || wr_gnt_i;
    win = -1;
    if (can) begin
      for (int pass = 0; pass < 2; pass++)
        for (int k = 0; k < 3; k++)
          if (win < 0 && en[order[k]] && ((pass == 0) == (lose_cnt[order[k]] >= MaxWait)))
            win = order[k];
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    seen = {tmac_gnt_o, mfpu_gnt_o, alu_gnt_o};
    chk("grant", 64'(seen), 64'(eg));
    chk("wr_req", 64'(wr_req_o), 64'(m_valid));
    chk("busy", 64'(busy_o), 64'(m_valid | en[0] | en[1] | en[2]));
    if (win >= 0) begin
      exp_q.push_back(pl[win]);
      m_valid = 1'b1;
    end else if (wr_gnt_i) begin
      m_valid = 1'b0;
    end
    for (int r = 0; r < 3; r++)
      lose_cnt[r] = (en[r] && r != win) ? ((lose_cnt[r] + 1 > MaxWait) ? MaxWait : lose_cnt[r] + 1) : 0;
    @(negedge clk);
  endtask

  // monitor: compare every presented output word, retire it when the VRF takes it
  always @(negedge clk) begin
    #2;
    if (!rst_i && wr_req_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_payload: got %0h with no word expected", {wr_id_o, wr_addr_o, wr_wdata_o, wr_be_o});
      end else begin
        chk("out_payload", 64'({wr_id_o, wr_addr_o, wr_wdata_o, wr_be_o}), 64'(exp_q[0]));
        if (wr_gnt_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int win;
    logic [2:0] seen;
    logic [2:0] first_seen;
    int alu_first;
    int tmac_first;
    n_checks = 0;
    n_pass   = 0;
    m_valid  = 1'b0;
    rst_i    = 1'b1;
    wr_gnt_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rq[r] = 1'b0;
      pl[r] = '0;
      lose_cnt[r] = 0;
    end

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_req", 64'(wr_req_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_payload", 64'({wr_id_o, wr_addr_o, wr_wdata_o, wr_be_o}), 64'(0));
    chk("rst_grants", 64'({tmac_gnt_o, mfpu_gnt_o, alu_gnt_o}), 64'(0));
    rst_i = 1'b0;
    @(negedge clk);

    // single ALU request
    rq[0] = 1'b1;
    pl[0] = '{id: 3'd1, addr: 10'h010, data: 32'hDEAD, be: 4'hF};
    wr_gnt_i = 1'b1;
    step(win, seen);
    chk("single_gnt", 64'(seen), 64'(3'b001));
    rq[0] = 1'b0;
    #1;
    chk("single_valid", 64'(wr_req_o), 64'(1));
    chk("single_addr", 64'(wr_addr_o), 64'(10'h010));
    chk("single_data", 64'(wr_wdata_o), 64'(32'hDEAD));
    step(win, seen);

    // contention: all three requesters hold their requests
    alu_first  = -1;
    tmac_first = -1;
    first_seen = '0;
    for (int r = 0; r < 3; r++) begin
      rq[r] = 1'b1;
      pl[r] = rand_pl();
    end
    for (int c = 0; c < 8; c++) begin
      step(win, seen);
      if (c == 0) first_seen = seen;
      if (seen[0] && alu_first < 0) alu_first = c;
      if (seen[2] && tmac_first < 0) tmac_first = c;
      if (win >= 0) pl[win] = rand_pl();
    end
    chk("first_mfpu", 64'(first_seen), 64'(3'b010));
    chk("alu_wait", 64'(alu_first >= 0 && alu_first <= 5), 64'(1));
    chk("tmac_wait", 64'(TmacEn ? (tmac_first >= 0 && tmac_first <= 6) : (tmac_first == -1)), 64'(1));

    // back-pressure for 6 cycles, then release
    wr_gnt_i = 1'b0;
    repeat (6) step(win, seen);
    wr_gnt_i = 1'b1;
    step(win, seen);
    if (win >= 0) pl[win] = rand_pl();
    #1;
    chk("bp_reload_valid", 64'(wr_req_o), 64'(1));
    for (int r = 0; r < 3; r++) rq[r] = 1'b0;
    repeat (2) step(win, seen);

    // withdrawal: TMAC loses to MFPU, then drops its request
    rq[1] = 1'b1;
    pl[1] = rand_pl();
    rq[2] = 1'b1;
    pl[2] = rand_pl();
    repeat (3) begin
      step(win, seen);
      if (win == 1) pl[1] = rand_pl();
    end
    rq[2] = 1'b0;
    repeat (3) begin
      step(win, seen);
      if (win == 1) pl[1] = rand_pl();
    end
    rq[1] = 1'b0;
    repeat (2) step(win, seen);

    // randomized traffic with random VRF back-pressure and withdrawals
    for (int i = 0; i < 3000; i++) begin
      wr_gnt_i = ($urandom_range(0, 99) < 70);
      for (int r = 0; r < 3; r++) begin
        if (!rq[r]) begin
          if ($urandom_range(0, 99) < 40) begin
            rq[r] = 1'b1;
            pl[r] = rand_pl();
          end
        end else if ($urandom_range(0, 99) < 4) begin
          rq[r] = 1'b0;
        end
      end
      step(win, seen);
      if (win >= 0) rq[win] = 1'b0;
    end
    for (int r = 0; r < 3; r++) rq[r] = 1'b0;
    wr_gnt_i = 1'b1;
    repeat (2) step(win, seen);

    // reset mid-operation: let TMAC age behind MFPU, then reset with a word held
    rq[1] = 1'b1;
    pl[1] = rand_pl();
    rq[2] = 1'b1;
    pl[2] = rand_pl();
    repeat (6) begin
      step(win, seen);
      if (win == 1) pl[1] = rand_pl();
    end
    rst_i = 1'b1;
    for (int r = 0; r < 3; r++) rq[r] = 1'b0;
    #1;
    chk("mid_rst_wr_req", 64'(wr_req_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_payload", 64'({wr_id_o, wr_addr_o, wr_wdata_o, wr_be_o}), 64'(0));
    exp_q.delete();
    m_valid = 1'b0;
    for (int r = 0; r < 3; r++) lose_cnt[r] = 0;
    #2;
    rst_i = 1'b0;
    rq[0] = 1'b1;
    pl[0] = rand_pl();
    rq[2] = 1'b1;
    pl[2] = rand_pl();
    step(win, seen);
    chk("post_rst_alu_first", 64'(seen), 64'(3'b001));
    rq[0] = 1'b0;
    repeat (3) begin
      step(win, seen);
      if (win >= 0) rq[win] = 1'b0;
    end
    for (int r = 0; r < 3; r++) rq[r] = 1'b0;
    repeat (2) step(win, seen);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
